codec_reg_arbiter: RTL



---
 rtl/codec_arb_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 32 +++
 rtl/codec_reg_arbiter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/codec_arb_pkg.sv
// Shared types and default widths for the codec register-port arbiter.
package codec_arb_pkg;

    localparam int unsigned DefAddrW = 7;
    localparam int unsigned DefDataW = 8;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitBusy,
        StWaitDone,
        StResp
    } arb_state_t;

    // Transaction descriptor at the default codec register widths.
    typedef struct packed {
        logic                wr;
        logic [DefAddrW-1:0] addr;
        logic [DefDataW-1:0] wdata;
    } codec_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request after last_grant_i, wrapping.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] last_grant_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [$clog2(NUM_REQ)-1:0] gnt_idx_o
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);

    logic found;

    // Walk offsets 1..NUM_REQ from the last grant; the modulo is folded into the compare.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            for (int unsigned j = 0; j < NUM_REQ; j++) begin
                if (!found && req_i[j] &&
                    ((32'(last_grant_i) + off == j) || (32'(last_grant_i) + off == j + NUM_REQ))) begin
                    found     = 1'b1;
                    gnt_o[j]  = 1'b1;
                    gnt_idx_o = IdxW'(j);
                end
            end
        end
    end

endmodule

// File: rtl/codec_reg_arbiter.sv
// Shares the codec register port between requesters, one transaction at a time,
// completing on the I2C controller's busy handshake with timeouts.
module codec_reg_arbiter
    import codec_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 3,
    parameter int unsigned ADDR_W    = DefAddrW,
    parameter int unsigned DATA_W    = DefDataW,
    parameter int unsigned BUSY_WAIT = 16,
    parameter int unsigned TIMEOUT   = 65535
) (
    input  logic                      s00_axi_aclk,
    input  logic                      s00_axi_aresetn,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_wr,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_error,
    output logic                      codec_rd_en,
    output logic                      codec_wr_en,
    output logic [ADDR_W-1:0]         codec_reg_addr,
    output logic [DATA_W-1:0]         codec_data_in,
    input  logic [DATA_W-1:0]         codec_data_out,
    input  logic                      controller_busy,
    input  logic                      init_done,
    output logic                      arb_busy
);

    localparam int unsigned IdxW   = $clog2(NUM_REQ);
    localparam int unsigned CntMax = (TIMEOUT > BUSY_WAIT) ? TIMEOUT : BUSY_WAIT;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam logic [CntW-1:0] BusyLimit = CntW'(BUSY_WAIT - 1);
    localparam logic [CntW-1:0] DoneLimit = CntW'(TIMEOUT - 1);
    localparam logic [IdxW-1:0] LastReset = IdxW'(NUM_REQ - 1);

    arb_state_t          state_q;
    logic [IdxW-1:0]     last_grant_q;
    logic [IdxW-1:0]     gnt_idx_q;
    logic                wr_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [CntW-1:0]     cnt_q;
    logic [NUM_REQ-1:0]  rsp_valid_q;
    logic                rsp_error_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                rd_en_q;
    logic                wr_en_q;

    logic [NUM_REQ-1:0]  gnt_oh;
    logic [IdxW-1:0]     gnt_idx;
    logic                grant_ok;
    logic [NUM_REQ-1:0]  done_oh;
    logic                sel_wr;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_rr_arbiter (
        .req_i       (req_valid),
        .last_grant_i(last_grant_q),
        .gnt_o       (gnt_oh),
        .gnt_idx_o   (gnt_idx)
    );

    // Accept only from IDLE, with the codec initialised and its controller idle.
    assign grant_ok  = s00_axi_aresetn && (state_q == StIdle) && init_done &&
                       !controller_busy && (|req_valid);
    assign req_ready = grant_ok ? gnt_oh : '0;
    assign done_oh   = {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_idx_q;

    // Mux out the granted requester's fields using the one-hot grant.
    always_comb begin
        sel_wr    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt_oh[i]) begin
                sel_wr    = req_wr[i];
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Transaction FSM with its wait counter, request latches and registered strobes.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            state_q      <= StIdle;
            last_grant_q <= LastReset;
            gnt_idx_q    <= '0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            rsp_valid_q  <= '0;
            rsp_error_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            rd_en_q      <= 1'b0;
            wr_en_q      <= 1'b0;
        end else begin
            // Strobes and response flags are single-cycle pulses.
            rd_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            rsp_valid_q <= '0;
            rsp_error_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (grant_ok) begin
                        gnt_idx_q <= gnt_idx;
                        wr_q      <= sel_wr;
                        addr_q    <= sel_addr;
                        wdata_q   <= sel_wdata;
                        wr_en_q   <= sel_wr;
                        rd_en_q   <= ~sel_wr;
                        state_q   <= StIssue;
                    end
                end
                StIssue: begin
                    cnt_q   <= '0;
                    state_q <= StWaitBusy;
                end
                StWaitBusy: begin
                    if (controller_busy) begin
                        cnt_q   <= '0;
                        state_q <= StWaitDone;
                    end else if (cnt_q == BusyLimit) begin
                        rsp_valid_q <= done_oh;
                        rsp_error_q <= 1'b1;
                        state_q     <= StResp;
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StWaitDone: begin
                    if (!controller_busy) begin
                        if (!wr_q) begin
                            rsp_rdata_q <= codec_data_out;
                        end
                        rsp_valid_q <= done_oh;
                        state_q     <= StResp;
                    end else if (cnt_q == DoneLimit) begin
                        rsp_valid_q <= done_oh;
                        rsp_error_q <= 1'b1;
                        state_q     <= StResp;
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StResp: begin
                    last_grant_q <= gnt_idx_q;
                    state_q      <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign rsp_valid      = rsp_valid_q;
    assign rsp_error      = rsp_error_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign codec_rd_en    = rd_en_q;
    assign codec_wr_en    = wr_en_q;
    assign codec_reg_addr = addr_q;
    assign codec_data_in  = wdata_q;
    assign arb_busy       = (state_q != StIdle);

endmodule
